jtdsp16_sio_rx: RTL and testbench
=================================

Name: jtdsp16_sio_rx

Overview:
Serial input receiver for the DSP16 core. Drives the DI/ICK/ILD/IBF pin group that the output-side serial block leaves unused.
- Synchronises the external serial input pins into the clk domain and deframes 8- or 16-bit words.
- Presents each completed word to the CPU as the SDX input register and raises IBF.
- Runs on the cen2 clock enable, alongside jtdsp16_sio (transmitter) and jtdsp16_pio (which consumes ibf for interrupts).

Parameters:
SYNC_STAGES, 2, number of flip-flop stages (cen-gated) on di/ick/ild before edge detection; legal range 2..4.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
cen  input  1  clock enable (cen2); all state except reset updates only when cen=1
di  input  1  serial data input pin
ick  input  1  serial input bit clock pin, asynchronous to clk
ild  input  1  input load / frame strobe pin, high marks first bit of a word
ilen  input  1  word length from SIOC: 0=16 bits, 1=8 bits
msb_first  input  1  bit order from SIOC: 1=MSB first, 0=LSB first
sdx_read  input  1  CPU read strobe of SDX, one cen cycle wide
sdx_dout  output  16  input buffer contents, right-justified, zero-extended in 8-bit mode
ibf  output  1  input buffer full
ovf  output  1  sticky overrun flag (optional feature only, else tied 0)

Behaviour:
Reset:
- All outputs 0, shift register 0, bit counter 0, state IDLE.
- All synchroniser stages and the previous-ick register reset to 0.
- Reset deassertion mid-word discards the partial word; no ibf pulse follows.

Synchronisation and edge detection:
- di, ick, ild each pass through SYNC_STAGES cen-gated flip-flops.
- A bit event occurs when synchronised ick=1 and the previous synchronised ick=0, evaluated on cen cycles.
- di and ild are sampled from their synchronised values in that same cycle.
- Each ick level must last at least SYNC_STAGES+1 cen cycles; faster clocks are unsupported.

State machine (IDLE, SHIFT):
- IDLE, bit event with ild=1:
  - Latch ilen and msb_first for the whole word.
  - Insert the bit, set cnt=1, go to SHIFT.
  - Bit events with ild=0 are ignored.
- SHIFT, bit event with ild=0: insert the bit, cnt=cnt+1.
- SHIFT, bit event with ild=1 (reframe): discard the partial word, treat this bit as bit 1 of a new word, set cnt=1, re-latch ilen and msb_first.
- Word completes when the inserted bit makes cnt equal to len (16 or 8). On the same cen cycle, load the buffer and return to IDLE.
- For len=8, ild=1 on the completing bit is a reframe, not a completion; the reframe rule takes priority.

Bit insertion:
- msb_first=1: sr <= {sr[14:0], di}. Buffer gets sr (16-bit) or {8'h00, sr[7:0]} (8-bit).
- msb_first=0: sr <= {di, sr[15:1]}. Buffer gets sr (16-bit) or {8'h00, sr[15:8]} (8-bit).
- The buffer value includes the completing bit.

Buffer and handshake:
- sdx_dout changes only on word completion.
- ibf is set on the cen cycle following the completing edge detection, aligned with sdx_dout update.
- Latency from the ick pin rising edge to ibf: SYNC_STAGES+1 cen cycles, plus up to 1 cen cycle of pin-to-enable phase.
- sdx_read with cen=1 clears ibf on the next cycle; sdx_dout holds its value.
- sdx_read coincident with completion: the new word loads and ibf stays 1 (set wins).
- Completion while ibf=1 (overrun): sdx_dout is overwritten with the newest word and ibf stays 1.
- sdx_read has no effect while ibf=0.

Optional Feature:
JTDSP16_SIO_RX_OVF_EN
- Defined:
  - Completion while ibf=1 and sdx_read=0 sets ovf.
  - ovf clears on the cycle after an sdx_read.
  - A read coincident with an overrun leaves ovf set.
- Undefined: ovf is constant 0 and the overrun logic is not synthesised.
- Data behaviour is identical in both builds.

Test Plan:
- 16-bit MSB-first (ilen=0, msb_first=1): ild=1 on first bit, shift 0xA5C3 → sdx_dout=16'hA5C3, ibf=1 exactly SYNC_STAGES+1 cen cycles after the 16th ick rise.
- 8-bit LSB-first (ilen=1, msb_first=0): shift 0x3C LSB first → sdx_dout=16'h003C, ibf=1. Then pulse sdx_read → ibf=0 next cycle, sdx_dout still 16'h003C.
- Overrun: receive 0x1234, no read, then receive 0xBEEF → sdx_dout=16'hBEEF, ibf=1. With JTDSP16_SIO_RX_OVF_EN, ovf=1 until read; without it, ovf=0 throughout.
- Reframe: send 5 bits, then raise ild on the 6th bit and send 0x00FF in 16-bit MSB-first from that bit → sdx_dout=16'h00FF, and only one ibf set event occurs.
- Reset mid-word: assert rst_n=0 after 9 bits → ibf=0, sdx_dout=0. Release and send 0x8001 → sdx_dout=16'h8001.
- Simultaneous read and completion: sdx_read on the completion cycle of 0x5555 while ibf=1 → ibf remains 1, sdx_dout=16'h5555.

Source files
------------

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial input receiver: synchronises DI/ICK/ILD, deframes 8/16-bit words into SDX and raises IBF.
// Optional sticky overrun flag enabled by defining JTDSP16_SIO_RX_OVF_EN.
module jtdsp16_sio_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        di,
    input  logic        ick,
    input  logic        ild,
    input  logic        ilen,
    input  logic        msb_first,
    input  logic        sdx_read,
    output logic [15:0] sdx_dout,
    output logic        ibf,
    output logic        ovf
);

    typedef enum logic { IDLE = 1'b0, SHIFT = 1'b1 } state_t;

    logic [SYNC_STAGES-1:0] di_sync, ick_sync, ild_sync;
    logic                   ick_prev;
    state_t                 state;
    logic [4:0]             cnt;
    logic [15:0]            sr;
    logic                   len8_r, msb_r;

    logic        di_s, ick_s, ild_s;
    logic        bit_event, new_word, complete;
    logic        word_msb, word_len8;
    logic [15:0] base_sr, ins_sr, word_val;
    logic [4:0]  cnt_next, word_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            di_sync  <= '0;
            ick_sync <= '0;
            ild_sync <= '0;
            ick_prev <= 1'b0;
        end else if (cen) begin
            di_sync  <= {di_sync[SYNC_STAGES-2:0], di};
            ick_sync <= {ick_sync[SYNC_STAGES-2:0], ick};
            ild_sync <= {ild_sync[SYNC_STAGES-2:0], ild};
            ick_prev <= ick_sync[SYNC_STAGES-1];
        end
    end

    assign di_s  = di_sync[SYNC_STAGES-1];
    assign ick_s = ick_sync[SYNC_STAGES-1];
    assign ild_s = ild_sync[SYNC_STAGES-1];

    // A frame strobe on any bit event starts a new word, also mid-word (reframe).
    always_comb begin
        bit_event = cen & ick_s & ~ick_prev;
        new_word  = bit_event & ild_s;
        word_msb  = new_word ? msb_first : msb_r;
        word_len8 = new_word ? ilen : len8_r;
        word_len  = word_len8 ? 5'd8 : 5'd16;
        base_sr   = new_word ? 16'h0000 : sr;
        ins_sr    = word_msb ? {base_sr[14:0], di_s} : {di_s, base_sr[15:1]};
        cnt_next  = new_word ? 5'd1 : cnt + 5'd1;
        complete  = bit_event & ~ild_s & (state == SHIFT) & (cnt_next == word_len);
        if (!word_len8)
            word_val = ins_sr;
        else if (word_msb)
            word_val = {8'h00, ins_sr[7:0]};
        else
            word_val = {8'h00, ins_sr[15:8]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            sr     <= 16'h0000;
            len8_r <= 1'b0;
            msb_r  <= 1'b0;
        end else if (new_word) begin
            state  <= SHIFT;
            cnt    <= 5'd1;
            sr     <= ins_sr;
            len8_r <= ilen;
            msb_r  <= msb_first;
        end else if (bit_event && state == SHIFT) begin
            sr  <= ins_sr;
            if (complete) begin
                state <= IDLE;
                cnt   <= 5'd0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

    // Handshake: a completed word loads sdx_dout and sets ibf; a cen-qualified
    // sdx_read clears ibf, but a completion in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdx_dout <= 16'h0000;
            ibf      <= 1'b0;
        end else if (cen) begin
            if (complete) begin
                sdx_dout <= word_val;
                ibf      <= 1'b1;
            end else if (sdx_read) begin
                ibf <= 1'b0;
            end
        end
    end

`ifdef JTDSP16_SIO_RX_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (cen) begin
            if (complete && ibf)
                ovf <= ovf | ~sdx_read;
            else if (sdx_read)
                ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Bench for jtdsp16_sio_rx: directed scenarios plus randomized words against a word-level model.
module tb_jtdsp16_sio_rx;
    localparam int S    = 2;
    localparam int HALF = S + 2;
`ifdef JTDSP16_SIO_RX_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
    logic di = 1'b0, ick = 1'b0, ild = 1'b0, ilen = 1'b0, msb_first = 1'b1, sdx_read = 1'b0;
    logic [15:0] sdx_dout;
    logic ibf, ovf;

    jtdsp16_sio_rx #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .di(di), .ick(ick), .ild(ild),
        .ilen(ilen), .msb_first(msb_first), .sdx_read(sdx_read),
        .sdx_dout(sdx_dout), .ibf(ibf), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_dout = 16'h0000;
    logic exp_ibf = 1'b0, exp_ovf = 1'b0;
    int ibf_rises = 0;
    logic ibf_prev = 1'b0;

    always @(negedge clk) begin
        if (ibf === 1'b1 && ibf_prev === 1'b0) ibf_rises++;
        ibf_prev = ibf;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cen cycle: exactly one active clock edge with cen=1, returns at a negedge.
    task automatic step;
        @(negedge clk) cen = 1'b1;
        @(negedge clk) cen = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic ld);
        ick = 1'b0; di = b; ild = ld;
        repeat (HALF) step();
        ick = 1'b1;
        repeat (HALF) step();
    endtask

    // Final bit: measures cen cycles from ick rise to ibf rise, optionally reads at step read_at.
    task automatic send_last(input logic b, input int read_at, output int lat);
        logic was;
        ick = 1'b0; di = b; ild = 1'b0;
        repeat (HALF) step();
        ick = 1'b1;
        lat = -1;
        was = ibf;
        for (int k = 1; k <= HALF; k++) begin
            sdx_read = (k == read_at);
            step();
            sdx_read = 1'b0;
            if (lat < 0 && ibf === 1'b1 && was === 1'b0) lat = k;
        end
    endtask

    function automatic logic pick_bit(input logic [15:0] w, input int n, input logic msb, input int i);
        return msb ? w[n-1-i] : w[i];
    endfunction

    // Sends a whole word; word-length/order pins are scrambled after the first bit.
    task automatic send_word(input logic [15:0] w, input logic len8, input logic msb,
                             input int read_at, output int lat);
        int n;
        n = len8 ? 8 : 16;
        ilen = len8; msb_first = msb;
        for (int i = 0; i < n - 1; i++) begin
            send_bit(pick_bit(w, n, msb, i), i == 0);
            if (i == 0) begin
                ilen = 1'($urandom); msb_first = 1'($urandom);
            end
        end
        send_last(pick_bit(w, n, msb, n - 1), read_at, lat);
    endtask

    task automatic model_complete(input logic [15:0] w, input logic len8, input logic rd);
        if (OVF_EN && exp_ibf && !rd) exp_ovf = 1'b1;
        exp_ibf = 1'b1;
        exp_dout = len8 ? {8'h00, w[7:0]} : w;
    endtask

    task automatic do_read;
        sdx_read = 1'b1;
        step();
        sdx_read = 1'b0;
        if (exp_ibf) begin
            exp_ibf = 1'b0;
            exp_ovf = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        vectors++; if (sdx_dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout: got %h want 0000", sdx_dout); end
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL reset_ibf: got %b want 0", ibf); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_msb16;
        int lat;
        send_word(16'hA5C3, 1'b0, 1'b1, 0, lat);
        model_complete(16'hA5C3, 1'b0, 1'b0);
        vectors++; if (lat !== S + 1) begin miscompares++; $display("FAIL msb16_latency: got %0d want %0d", lat, S + 1); end
        vectors++; if (sdx_dout !== exp_dout) begin miscompares++; $display("FAIL msb16_dout: got %h want %h", sdx_dout, exp_dout); end
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL msb16_ibf: got %b want 1", ibf); end
        do_read();
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL msb16_read_ibf: got %b want 0", ibf); end
    endtask

    task automatic test_lsb8;
        int lat;
        send_word(16'h003C, 1'b1, 1'b0, 0, lat);
        model_complete(16'h003C, 1'b1, 1'b0);
        vectors++; if (sdx_dout !== 16'h003C) begin miscompares++; $display("FAIL lsb8_dout: got %h want 003c", sdx_dout); end
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL lsb8_ibf: got %b want 1", ibf); end
        vectors++; if (lat !== S + 1) begin miscompares++; $display("FAIL lsb8_latency: got %0d want %0d", lat, S + 1); end
        do_read();
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL lsb8_read_ibf: got %b want 0", ibf); end
        vectors++; if (sdx_dout !== 16'h003C) begin miscompares++; $display("FAIL lsb8_hold: got %h want 003c", sdx_dout); end
        do_read();
        vectors++; if (ibf !== 1'b0 || sdx_dout !== 16'h003C) begin miscompares++; $display("FAIL lsb8_idle_read: got ibf=%b dout=%h want 0/003c", ibf, sdx_dout); end
    endtask

    task automatic test_overrun;
        int lat;
        send_word(16'h1234, 1'b0, 1'b1, 0, lat);
        model_complete(16'h1234, 1'b0, 1'b0);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovr_first_ovf: got %b want 0", ovf); end
        send_word(16'hBEEF, 1'b0, 1'b1, 0, lat);
        model_complete(16'hBEEF, 1'b0, 1'b0);
        vectors++; if (sdx_dout !== 16'hBEEF) begin miscompares++; $display("FAIL ovr_dout: got %h want beef", sdx_dout); end
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL ovr_ibf: got %b want 1", ibf); end
        vectors++; if (ovf !== exp_ovf) begin miscompares++; $display("FAIL ovr_ovf: got %b want %b", ovf, exp_ovf); end
        do_read();
        vectors++; if (ovf !== 1'b0 || ibf !== 1'b0) begin miscompares++; $display("FAIL ovr_read: got ovf=%b ibf=%b want 0/0", ovf, ibf); end
    endtask

    task automatic test_reframe;
        int lat, rises0;
        rises0 = ibf_rises;
        ilen = 1'b0; msb_first = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), i == 0);
        send_word(16'h00FF, 1'b0, 1'b1, 0, lat);
        model_complete(16'h00FF, 1'b0, 1'b0);
        vectors++; if (sdx_dout !== 16'h00FF) begin miscompares++; $display("FAIL reframe_dout: got %h want 00ff", sdx_dout); end
        vectors++; if (ibf_rises - rises0 !== 1) begin miscompares++; $display("FAIL reframe_ibf_events: got %0d want 1", ibf_rises - rises0); end
        ilen = 1'b1; msb_first = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), i == 0);
        send_word(16'h00A6, 1'b1, 1'b1, 0, lat);
        model_complete(16'h00A6, 1'b1, 1'b0);
        vectors++; if (sdx_dout !== 16'h00A6) begin miscompares++; $display("FAIL reframe8_dout: got %h want 00a6", sdx_dout); end
        do_read();
    endtask

    task automatic test_reset_mid;
        int lat;
        ilen = 1'b0; msb_first = 1'b1;
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), i == 0);
        rst_n = 1'b0;
        step();
        exp_ibf = 1'b0; exp_ovf = 1'b0; exp_dout = 16'h0000;
        vectors++; if (ibf !== 1'b0 || sdx_dout !== 16'h0000) begin miscompares++; $display("FAIL rstmid: got ibf=%b dout=%h want 0/0000", ibf, sdx_dout); end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0);
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_ibf: got %b want 0", ibf); end
        send_word(16'h8001, 1'b0, 1'b1, 0, lat);
        model_complete(16'h8001, 1'b0, 1'b0);
        vectors++; if (sdx_dout !== 16'h8001) begin miscompares++; $display("FAIL rstmid_dout: got %h want 8001", sdx_dout); end
        do_read();
    endtask

    task automatic test_simul_read;
        int lat;
        send_word(16'h1234, 1'b0, 1'b1, 0, lat);
        model_complete(16'h1234, 1'b0, 1'b0);
        send_word(16'h5555, 1'b0, 1'b0, S + 1, lat);
        model_complete(16'h5555, 1'b0, 1'b1);
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL simul_ibf: got %b want 1", ibf); end
        vectors++; if (sdx_dout !== 16'h5555) begin miscompares++; $display("FAIL simul_dout: got %h want 5555", sdx_dout); end
        vectors++; if (ovf !== exp_ovf) begin miscompares++; $display("FAIL simul_ovf: got %b want %b", ovf, exp_ovf); end
        do_read();
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL simul_read_ibf: got %b want 0", ibf); end
    endtask

    task automatic test_random;
        int lat, rd_at;
        logic [15:0] w, got_exp;
        logic len8, msb, was_ibf;
        for (int it = 0; it < 40; it++) begin
            w = 16'($urandom);
            len8 = 1'($urandom);
            msb = 1'($urandom);
            rd_at = ($urandom_range(0, 3) == 0) ? S + 1 : 0;
            if ($urandom_range(0, 1) == 1) do_read();
            was_ibf = exp_ibf;
            exp_q.push_back(len8 ? {8'h00, w[7:0]} : w);
            send_word(w, len8, msb, rd_at, lat);
            model_complete(w, len8, rd_at != 0);
            got_exp = exp_q.pop_front();
            vectors++; if (sdx_dout !== got_exp) begin miscompares++; $display("FAIL rand_dout[%0d]: got %h want %h", it, sdx_dout, got_exp); end
            vectors++; if (ibf !== exp_ibf) begin miscompares++; $display("FAIL rand_ibf[%0d]: got %b want %b", it, ibf, exp_ibf); end
            vectors++; if (ovf !== exp_ovf) begin miscompares++; $display("FAIL rand_ovf[%0d]: got %b want %b", it, ovf, exp_ovf); end
            if (!was_ibf) begin
                vectors++; if (lat !== S + 1) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, S + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb16();
        test_lsb8();
        test_overrun();
        test_reframe();
        test_reset_mid();
        test_simul_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
